// File: rtl/multi_register_file_if.sv
// Bus bundle for multi_register_file.
// The master drives clear, write and read requests. The slave returns the
// registered read result and the status flags.
interface multi_register_file_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) ();

  logic             clr;
  logic             w_en;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] in;
  logic             r_en;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] out;
  logic             r_valid;
  logic             r_uninit;
  logic             addr_err;

  modport master (
    output clr, w_en, w_addr, in, r_en, r_addr,
    input  out, r_valid, r_uninit, addr_err
  );

  modport slave (
    input  clr, w_en, w_addr, in, r_en, r_addr,
    output out, r_valid, r_uninit, addr_err
  );

endinterface

// File: rtl/multi_register_file.sv
// Bank of DEPTH scratch registers, each WIDTH bits wide.
// The bank has one write port and one read port, and both can be used in the
// same cycle. Read data is registered and appears one cycle after the request.
// Each entry has a written flag. Out-of-range accesses are detected and
// flagged.
// On a same-address read/write, MODE=0 returns the old contents and MODE=1
// returns the incoming data. The write completes in both modes.
module multi_register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int MODE  = 0
) (
  input logic                  clk,
  input logic                  rst,
  multi_register_file_if.slave bus
);

  // One extra bit so that DEPTH == 2**AW is still representable.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam bit          WT_C    = (MODE == 1);

  // Storage and per-entry written flags
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] wr_flag_q;
  logic [DEPTH-1:0] wr_flag_d;

  // Registered read result and status
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             r_valid_q;
  logic             r_valid_d;
  logic             r_uninit_q;
  logic             r_uninit_d;
  logic             addr_err_q;
  logic             addr_err_d;

  // Address qualification
  logic             w_in_range_s;
  logic             r_in_range_s;
  logic             w_ok_s;
  logic             r_ok_s;
  logic             coll_s;
  logic [DEPTH-1:0] w_sel_s;
  logic [DEPTH-1:0] r_sel_s;

  // Unregistered read mux outputs
  logic [WIDTH-1:0] rd_data_s;
  logic             rd_flag_s;

  // Qualify both addresses against DEPTH (unsigned) and detect a same-entry collision.
  always_comb begin
    w_in_range_s = ({1'b0, bus.w_addr} < DEPTH_C);
    r_in_range_s = ({1'b0, bus.r_addr} < DEPTH_C);
    w_ok_s       = bus.w_en & w_in_range_s;
    r_ok_s       = bus.r_en & r_in_range_s;
    coll_s       = w_ok_s & r_ok_s & (bus.w_addr == bus.r_addr);
  end

  // Decode one-hot entry selects; an out-of-range address selects no entry.
  always_comb begin
    w_sel_s = {DEPTH{1'b0}};
    r_sel_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_sel_s[i] = w_ok_s & (bus.w_addr == i[AW-1:0]);
      r_sel_s[i] = (bus.r_addr == i[AW-1:0]);
    end
  end

  // AND-OR read mux over the current (pre-write) contents and flags.
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    rd_flag_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_data_s = rd_data_s | (mem_q[i] & {WIDTH{r_sel_s[i]}});
      rd_flag_s = rd_flag_s | (wr_flag_q[i] & r_sel_s[i]);
    end
  end

  // Next bank state: clear wins over a same-cycle write; otherwise the selected entry is written.
  always_comb begin
    mem_d     = mem_q;
    wr_flag_d = wr_flag_q;
    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {WIDTH{1'b0}};
      end
      wr_flag_d = {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = w_sel_s[i] ? bus.in : mem_q[i];
      end
      wr_flag_d = wr_flag_q | w_sel_s;
    end
  end

  // Next read result: in-range reads see old contents (or new data under write-through),
  // out-of-range reads return zero and report uninitialised, and idle cycles hold data.
  always_comb begin
    out_d      = out_q;
    r_valid_d  = 1'b0;
    r_uninit_d = 1'b0;
    if (r_ok_s) begin
      r_valid_d = 1'b1;
      if (WT_C && coll_s) begin
        out_d      = bus.in;
        r_uninit_d = 1'b0;
      end else begin
        out_d      = rd_data_s;
        r_uninit_d = ~rd_flag_s;
      end
    end else if (bus.r_en) begin
      out_d      = {WIDTH{1'b0}};
      r_valid_d  = 1'b1;
      r_uninit_d = 1'b1;
    end else begin
      out_d      = out_q;
      r_valid_d  = 1'b0;
      r_uninit_d = 1'b0;
    end
    addr_err_d = (bus.w_en & ~w_in_range_s) | (bus.r_en & ~r_in_range_s);
  end

  // State registers; asynchronous reset clears the bank and every output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_flag_q  <= {DEPTH{1'b0}};
      out_q      <= {WIDTH{1'b0}};
      r_valid_q  <= 1'b0;
      r_uninit_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_flag_q  <= wr_flag_d;
      out_q      <= out_d;
      r_valid_q  <= r_valid_d;
      r_uninit_q <= r_uninit_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_uninit = r_uninit_q;
  assign bus.addr_err = addr_err_q;

endmodule
